// File: rtl/cond_pkg.sv
// cond_pkg: shared condition codes, flag bit positions and flag-write enable positions.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational condition-code evaluator over the registered NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            EQ: cond_ex = z;
            NE: cond_ex = ~z;
            CS: cond_ex = c;
            CC: cond_ex = ~c;
            MI: cond_ex = n;
            PL: cond_ex = ~n;
            VS: cond_ex = v;
            VC: cond_ex = ~v;
            HI: cond_ex = c & ~z;
            LS: cond_ex = ~c | z;
            GE: cond_ex = n == v;
            LT: cond_ex = n != v;
            GT: cond_ex = ~z & (n == v);
            LE: cond_ex = z | (n != v);
            AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_logic.sv
// cond_logic: condition-gated commit controls, NZCV flag register and
// saturating committed/skipped instruction counters.
module cond_logic
    import cond_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [3:0]  Cond,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  FlagW,
    input  logic        PCS,
    input  logic        RegW,
    input  logic        MemW,
    input  logic        NoWrite,
    input  logic        Valid,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        CntClr,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        CondEx,
    output logic [3:0]  Flags,
    output logic [15:0] ExecCount,
    output logic [15:0] SkipCount
);
    logic        cond_ex, commit, skip;
    logic [3:0]  flags_d, flags_q;
    logic [15:0] exec_d, exec_q, skip_d, skip_q;

    cond_check u_cond_check (.cond(Cond), .flags(flags_q), .cond_ex(cond_ex));

    assign commit = Valid & cond_ex & ~Stall & ~Flush;
    assign skip   = Valid & ~cond_ex & ~Stall & ~Flush;

    always_comb begin
        flags_d = flags_q;
        if (commit && FlagW[FW_NZ]) flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
        if (commit && FlagW[FW_CV]) flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
        exec_d = CntClr ? '0 : (commit && exec_q != CNT_MAX) ? exec_q + 16'd1 : exec_q;
        skip_d = CntClr ? '0 : (skip && skip_q != CNT_MAX) ? skip_q + 16'd1 : skip_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            flags_q <= '0;
            exec_q  <= '0;
            skip_q  <= '0;
        end else begin
            flags_q <= flags_d;
            exec_q  <= exec_d;
            skip_q  <= skip_d;
        end
    end

    // Gated controls are held low for the whole reset, not just after the flops clear.
    assign PCSrc     = RESET_N & PCS & commit;
    assign RegWrite  = RESET_N & RegW & ~NoWrite & commit;
    assign MemWrite  = RESET_N & MemW & commit;
    assign CondEx    = cond_ex;
    assign Flags     = flags_q;
    assign ExecCount = exec_q;
    assign SkipCount = skip_q;
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model of flags, gating and counters.
module tb_cond_logic;
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS, RegW, MemW, NoWrite, Valid, Stall, Flush, CntClr;
    logic        PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]  Flags;
    logic [15:0] ExecCount, SkipCount;

    int checks = 0;
    int errors = 0;

    cond_logic dut (
        .CLK(CLK), .RESET_N(RESET_N), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .Valid(Valid),
        .Stall(Stall), .Flush(Flush), .CntClr(CntClr), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags), .ExecCount(ExecCount),
        .SkipCount(SkipCount)
    );

    always #5 CLK = ~CLK;

    // Conditions come in complementary pairs: bits [3:1] pick a predicate, bit 0 inverts it.
    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = n == v;
            3'd6: r = !z && n == v;
            default: r = 1'b1;
        endcase
        return r ^ c[0];
    endfunction

    logic [3:0] m_flags;
    int         m_exec, m_skip;
    logic       m_live, m_pass;

    assign m_live = Valid && !Stall && !Flush;
    assign m_pass = m_cond(Cond, m_flags);

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_flags <= 4'h0;
            m_exec  <= 0;
            m_skip  <= 0;
        end else begin
            if (m_live && m_pass)
                m_flags <= {FlagW[1] ? ALUFlags[3:2] : m_flags[3:2],
                            FlagW[0] ? ALUFlags[1:0] : m_flags[1:0]};
            m_exec <= CntClr ? 0 : (m_live && m_pass) ? ((m_exec < 65535) ? m_exec + 1 : 65535) : m_exec;
            m_skip <= CntClr ? 0 : (m_live && !m_pass) ? ((m_skip < 65535) ? m_skip + 1 : 65535) : m_skip;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("pcsrc", int'(PCSrc), int'(RESET_N && PCS && m_live && m_pass));
        chk("regwrite", int'(RegWrite), int'(RESET_N && RegW && !NoWrite && m_live && m_pass));
        chk("memwrite", int'(MemWrite), int'(RESET_N && MemW && m_live && m_pass));
        chk("condex", int'(CondEx), int'(m_pass));
        chk("flags", int'(Flags), int'(m_flags));
        chk("exec", int'(ExecCount), m_exec);
        chk("skip", int'(SkipCount), m_skip);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        Valid = 0; Cond = 4'hE; ALUFlags = 0; FlagW = 0; PCS = 0; RegW = 0; MemW = 0;
        NoWrite = 0; Stall = 0; Flush = 0; CntClr = 0;
    endtask

    initial begin
        idle();
        RESET_N = 0;
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1;
        chk("rst_flags", int'(Flags), 0);
        chk("rst_exec", int'(ExecCount), 0);
        chk("rst_skip", int'(SkipCount), 0);

        // AL commit loads all flags, then probe EQ/NE/NV against them
        Valid = 1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0100;
        #1 chk("al_condex", int'(CondEx), 1);
        tick();
        chk("load_flags", int'(Flags), 4'b0100);
        FlagW = 0;
        Cond = 4'h0; #1 chk("eq_condex", int'(CondEx), 1);
        Cond = 4'h1; #1 chk("ne_condex", int'(CondEx), 0);
        Cond = 4'hF; #1 chk("nv_condex", int'(CondEx), 0);
        tick();

        Cond = 4'hE; FlagW = 2'b01; ALUFlags = 4'b1011;
        tick();
        chk("partial_flags", int'(Flags), 4'b0111);

        FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        idle(); CntClr = 1;
        tick();
        CntClr = 0;
        chk("clr_exec", int'(ExecCount), 0);
        chk("clr_skip", int'(SkipCount), 0);
        chk("clr_keeps_flags", int'(Flags), 0);

        Valid = 1; Cond = 4'h0; PCS = 1; RegW = 1; MemW = 1; FlagW = 2'b11; ALUFlags = 4'hF;
        #1 chk("fail_pcsrc", int'(PCSrc), 0);
        chk("fail_regwrite", int'(RegWrite), 0);
        chk("fail_memwrite", int'(MemWrite), 0);
        tick();
        chk("fail_flags", int'(Flags), 0);
        chk("fail_skip", int'(SkipCount), 1);
        chk("fail_exec", int'(ExecCount), 0);

        idle(); Valid = 1; Cond = 4'hE; RegW = 1; FlagW = 2'b11; ALUFlags = 4'b0110; Stall = 1; Flush = 1;
        #1 chk("sf_regwrite", int'(RegWrite), 0);
        tick();
        chk("sf_flags", int'(Flags), 0);
        chk("sf_exec", int'(ExecCount), 0);
        chk("sf_skip", int'(SkipCount), 1);
        Stall = 0; Flush = 0;
        #1 chk("go_regwrite", int'(RegWrite), 1);
        tick();
        chk("go_flags", int'(Flags), 4'b0110);
        chk("go_exec", int'(ExecCount), 1);

        idle();
        for (int i = 0; i < 3000; i++) begin
            Valid    = $urandom_range(0, 3) != 0;
            Cond     = 4'($urandom);
            ALUFlags = 4'($urandom);
            FlagW    = 2'($urandom);
            PCS      = 1'($urandom);
            RegW     = 1'($urandom);
            MemW     = 1'($urandom);
            NoWrite  = 1'($urandom);
            Stall    = $urandom_range(0, 4) == 0;
            Flush    = $urandom_range(0, 5) == 0;
            CntClr   = $urandom_range(0, 40) == 0;
            if ($urandom_range(0, 300) == 0) begin
                #2 RESET_N = 0;
                @(posedge CLK);
                #1 RESET_N = 1;
            end else begin
                tick();
            end
        end

        // Asynchronous reset between edges with a live committing instruction
        idle(); Valid = 1; FlagW = 2'b11; ALUFlags = 4'hF;
        tick();
        chk("ff_flags", int'(Flags), 4'hF);
        FlagW = 0; PCS = 1; RegW = 1; MemW = 1;
        #2 RESET_N = 0;
        #1 chk("arst_flags", int'(Flags), 0);
        chk("arst_pcsrc", int'(PCSrc), 0);
        chk("arst_regwrite", int'(RegWrite), 0);
        chk("arst_memwrite", int'(MemWrite), 0);
        chk("arst_exec", int'(ExecCount), 0);
        tick();
        RESET_N = 1;
        FlagW = 2'b11; ALUFlags = 4'b1010;
        tick();
        chk("post_rst_flags", int'(Flags), 4'b1010);
        chk("post_rst_exec", int'(ExecCount), 1);

        idle(); CntClr = 1;
        tick();
        CntClr = 0; Valid = 1; Cond = 4'hE;
        repeat (65540) @(posedge CLK);
        #1 chk("sat_exec", int'(ExecCount), 16'hFFFF);
        chk("sat_skip", int'(SkipCount), 0);
        CntClr = 1;
        tick();
        chk("clr_win_exec", int'(ExecCount), 0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
